// File: rtl/alu_acc_ctrl_pkg.sv
// alu_acc_ctrl_pkg: opcode and FSM encodings shared by the accumulator
// controller, its command FIFO and the 4-bit ALU select lines.
package alu_acc_ctrl_pkg;

  localparam int OP_W = 3;

  // Values 000..101 double as the ALU select encoding.
  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_NOT  = 3'b101,
    OP_LOAD = 3'b110,
    OP_ILL  = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_acc_ctrl_if.sv
// alu_acc_ctrl_if: command (valid/ready) and response (valid/ready) bundle.
// master = command source / response sink, slave = the controller.
interface alu_acc_ctrl_if #(
  parameter int WIDTH = 4
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_operand;

  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_carry;
  logic             res_zero;
  logic             res_neg;
  logic             res_err;

  modport master (
    output cmd_valid, cmd_op, cmd_operand, res_ready,
    input  cmd_ready, res_valid, res_data,
    input  res_carry, res_zero, res_neg, res_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_operand, res_ready,
    output cmd_ready, res_valid, res_data,
    output res_carry, res_zero, res_neg, res_err
  );

endinterface

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: synchronous FIFO, DW-bit words, DEPTH entries (power of 2).
// Ports: clk, rst (async high), push/wdata, pop/rdata, full, empty.
module alu_cmd_fifo #(
  parameter int DW    = 7,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers are AW bits wide, so +1 wraps modulo DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_acc_ctrl.sv
// alu_acc_ctrl: queues (op, operand) commands, runs them through the
// external ALU against the accumulator and returns result + flags.
// Ports: clk, rst (async high), bus (cmd/res handshakes),
// alu_a/alu_b/alu_sel to the ALU, alu_out/alu_carry from it.
// Option: define ALU_ACC_CTRL_SAT_EN for unsigned-saturating ADD.
module alu_acc_ctrl #(
  parameter int WIDTH      = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  alu_acc_ctrl_if.slave    bus,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_carry
);

  import alu_acc_ctrl_pkg::*;

  localparam int DW = OP_W + WIDTH;

  state_e           state;
  op_e              op_q;
  logic [WIDTH-1:0] opnd_q;
  logic [WIDTH-1:0] acc;
  logic             carry_q;

  logic [DW-1:0]    f_rdata;
  logic             f_full;
  logic             f_empty;
  logic             f_pop;
  op_e              f_op;
  logic [WIDTH-1:0] f_opnd;

  logic [WIDTH-1:0] nxt_acc;
  logic             nxt_carry;
  logic             nxt_err;

  assign bus.cmd_ready = !f_full;
  assign f_pop         = (state == IDLE) && !f_empty;
  assign f_op          = op_e'(f_rdata[DW-1 -: OP_W]);
  assign f_opnd        = f_rdata[WIDTH-1:0];

  alu_cmd_fifo #(
    .DW    (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.cmd_valid),
    .wdata ({bus.cmd_op, bus.cmd_operand}),
    .pop   (f_pop),
    .rdata (f_rdata),
    .full  (f_full),
    .empty (f_empty)
  );

  always_comb begin
    nxt_acc   = acc;
    nxt_carry = carry_q;
    nxt_err   = 1'b0;
    unique case (op_q)
      OP_ADD: begin
        nxt_carry = alu_carry;
`ifdef ALU_ACC_CTRL_SAT_EN
        nxt_acc   = alu_carry ? '1 : alu_out;
`else
        nxt_acc   = alu_out;
`endif
      end
      OP_SUB: begin
        nxt_acc   = alu_out;
        nxt_carry = alu_carry;
      end
      OP_AND, OP_OR, OP_XOR, OP_NOT: begin
        nxt_acc   = alu_out;
        nxt_carry = 1'b0;
      end
      OP_LOAD: begin
        nxt_acc   = opnd_q;
        nxt_carry = 1'b0;
      end
      OP_ILL: begin
        nxt_err = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      op_q          <= OP_ADD;
      opnd_q        <= '0;
      acc           <= '0;
      carry_q       <= 1'b0;
      alu_a         <= '0;
      alu_b         <= '0;
      alu_sel       <= '0;
      bus.res_valid <= 1'b0;
      bus.res_data  <= '0;
      bus.res_carry <= 1'b0;
      bus.res_zero  <= 1'b0;
      bus.res_neg   <= 1'b0;
      bus.res_err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!f_empty) begin
            alu_a  <= acc;
            alu_b  <= f_opnd;
            // LOAD and illegal never use the ALU; park it on ADD.
            alu_sel <= (f_op == OP_LOAD || f_op == OP_ILL)
                       ? 3'(OP_ADD) : 3'(f_op);
            op_q   <= f_op;
            opnd_q <= f_opnd;
            state  <= EXEC;
          end
        end
        EXEC: begin
          acc           <= nxt_acc;
          carry_q       <= nxt_carry;
          bus.res_data  <= nxt_acc;
          bus.res_carry <= nxt_carry;
          bus.res_zero  <= (nxt_acc == '0);
          bus.res_neg   <= nxt_acc[WIDTH-1];
          bus.res_err   <= nxt_err;
          bus.res_valid <= 1'b1;
          state         <= RESP;
        end
        RESP: begin
          if (bus.res_ready) begin
            bus.res_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_acc_ctrl.sv
// tb_alu_acc_ctrl: table-driven bench with a response scoreboard and a
// behavioural 4-bit ALU (carry = carry-out on ADD, borrow on SUB).
module tb_alu_acc_ctrl;

  typedef struct packed {
    logic [3:0] d;
    logic       c;
    logic       z;
    logic       n;
    logic       e;
  } exp_t;

  typedef struct packed {
    logic [2:0] op;
    logic [3:0] opnd;
    exp_t       x;
  } vec_t;

  logic       clk;
  logic       rst;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_sel;
  logic [3:0] alu_out;
  logic       alu_carry;

  int checks;
  int errors;
  int cyc;
  int hs_cyc;
  int last_pop_cyc;
  exp_t exp_q[$];

  alu_acc_ctrl_if #(.WIDTH(4)) bus();

  alu_acc_ctrl #(
    .WIDTH      (4),
    .FIFO_DEPTH (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_out   (alu_out),
    .alu_carry (alu_carry)
  );

  // Behavioural stand-in for the team's 4-bit ALU.
  always_comb begin
    logic [4:0] t;
    t = '0;
    case (alu_sel)
      3'b000:  t = {1'b0, alu_a} + {1'b0, alu_b};
      3'b001:  t = {1'b0, alu_a} - {1'b0, alu_b};
      3'b010:  t = {1'b0, alu_a & alu_b};
      3'b011:  t = {1'b0, alu_a | alu_b};
      3'b100:  t = {1'b0, alu_a ^ alu_b};
      3'b101:  t = {1'b0, ~alu_a};
      default: t = '0;
    endcase
    alu_out   = t[3:0];
    alu_carry = t[4];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t mk(input logic [3:0] d, input logic c,
                              input logic e);
    exp_t r;
    r.d = d;
    r.c = c;
    r.z = (d == 4'h0);
    r.n = d[3];
    r.e = e;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Response scoreboard: compare on each accepted response.
  always @(negedge clk) begin
    if (!rst && bus.res_valid && bus.res_ready) begin
      exp_t got;
      got = {bus.res_data, bus.res_carry, bus.res_zero,
             bus.res_neg, bus.res_err};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected: got %0h expected none", got);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL resp: got %0h expected %0h (d,c,z,n,e)",
                   got, e);
        end
      end
      last_pop_cyc = cyc;
    end
  end

  task automatic send(input logic [2:0] op, input logic [3:0] opnd,
                      input exp_t x);
    int w;
    w = 0;
    while (!bus.cmd_ready && w < 50) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (!bus.cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got ready 0 expected 1");
      return;
    end
    bus.cmd_valid   = 1'b1;
    bus.cmd_op      = op;
    bus.cmd_operand = opnd;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    hs_cyc        = cyc;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 60) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0",
               exp_q.size());
      exp_q.delete();
    end
  endtask

  vec_t vecs[15];

  initial begin
    logic [3:0] held;
    int         seen;
    checks = 0;
    errors = 0;
    cyc    = 0;
    hs_cyc = 0;
    last_pop_cyc = 0;

    vecs[0]  = {3'b110, 4'h6, mk(4'h6, 1'b0, 1'b0)};
    vecs[1]  = {3'b001, 4'h2, mk(4'h4, 1'b0, 1'b0)};
    vecs[2]  = {3'b110, 4'hC, mk(4'hC, 1'b0, 1'b0)};
    vecs[3]  = {3'b010, 4'hA, mk(4'h8, 1'b0, 1'b0)};
    vecs[4]  = {3'b011, 4'hA, mk(4'hA, 1'b0, 1'b0)};
    vecs[5]  = {3'b100, 4'hA, mk(4'h0, 1'b0, 1'b0)};
    vecs[6]  = {3'b110, 4'hF, mk(4'hF, 1'b0, 1'b0)};
`ifdef ALU_ACC_CTRL_SAT_EN
    vecs[7]  = {3'b000, 4'h1, mk(4'hF, 1'b1, 1'b0)};
    vecs[8]  = {3'b101, 4'h0, mk(4'h0, 1'b0, 1'b0)};
`else
    vecs[7]  = {3'b000, 4'h1, mk(4'h0, 1'b1, 1'b0)};
    vecs[8]  = {3'b101, 4'h0, mk(4'hF, 1'b0, 1'b0)};
`endif
    vecs[9]  = {3'b110, 4'h2, mk(4'h2, 1'b0, 1'b0)};
    vecs[10] = {3'b001, 4'h3, mk(4'hF, 1'b1, 1'b0)};
    vecs[11] = {3'b111, 4'h9, mk(4'hF, 1'b1, 1'b1)};
    vecs[12] = {3'b110, 4'h5, mk(4'h5, 1'b0, 1'b0)};
    vecs[13] = {3'b111, 4'h0, mk(4'h5, 1'b0, 1'b1)};
    vecs[14] = {3'b000, 4'h1, mk(4'h6, 1'b0, 1'b0)};

    rst             = 1'b1;
    bus.cmd_valid   = 1'b0;
    bus.cmd_op      = '0;
    bus.cmd_operand = '0;
    bus.res_ready   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_res", 32'({bus.res_valid, bus.res_data, bus.res_carry,
                        bus.res_zero, bus.res_neg, bus.res_err}), 0);
    chk("rst_alu", 32'({alu_a, alu_b, alu_sel}), 0);
    chk("rst_ready", 32'(bus.cmd_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // LOAD then ADD from empty/IDLE: latency check.
    send(3'b110, 4'h3, mk(4'h3, 1'b0, 1'b0));
    drain();
    send(3'b000, 4'h1, mk(4'h4, 1'b0, 1'b0));
    drain();
    chk("latency", 32'(last_pop_cyc - hs_cyc), 2);

    foreach (vecs[i]) send(vecs[i].op, vecs[i].opnd, vecs[i].x);
    drain();

    // Back-pressure: three commands with res_ready held low.
    bus.res_ready = 1'b0;
    send(3'b110, 4'h1, mk(4'h1, 1'b0, 1'b0));
    send(3'b000, 4'h1, mk(4'h2, 1'b0, 1'b0));
    send(3'b000, 4'h1, mk(4'h3, 1'b0, 1'b0));
    chk("bp_full_ready", 32'(bus.cmd_ready), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_valid", 32'(bus.res_valid), 1);
    held = bus.res_data;
    chk("bp_data", 32'(held), 1);
    repeat (4) @(posedge clk);
    #1;
    chk("bp_hold", 32'({bus.res_valid, bus.res_data}), 32'({1'b1, held}));
    chk("bp_still_full", 32'(bus.cmd_ready), 0);
    bus.res_ready = 1'b1;
    drain();

    // Reset while in EXEC.
    send(3'b110, 4'h7, mk(4'h7, 1'b0, 1'b0));
    drain();
    send(3'b000, 4'h1, mk(4'h8, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    chk("exec_alu_a", 32'({alu_a, alu_b}), 32'h71);
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("rst_mid_res", 32'({bus.res_valid, bus.res_data, bus.res_carry,
                            bus.res_zero, bus.res_neg, bus.res_err}), 0);
    chk("rst_mid_alu", 32'({alu_a, alu_b, alu_sel}), 0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.res_valid) seen++;
    end
    chk("rst_no_resp", 32'(seen), 0);
    @(posedge clk);
    #1;
    send(3'b000, 4'h2, mk(4'h2, 1'b0, 1'b0));
    drain();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
